// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: load-use stall, branch flush and memory-wait freeze.
// Optional macro HAZARD_STALL_COUNTER_EN adds a 16-bit count of cycles with pc_en low.
module pipeline_hazard_controller #(
  parameter logic [5:0] LOAD_OP      = 6'b010100,
  parameter logic [5:0] STORE_OP     = 6'b010101,
  parameter logic [5:0] RTYPE_OP     = 6'b000000,
  parameter int         FLUSH_CYCLES = 2,
  parameter int         MAX_HOLD     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ins_id,
  input  logic        id_valid,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_rd,
  input  logic        branch_taken,
  input  logic        mem_wait,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        idex_bubble,
  output logic        ifid_flush,
  output logic        hold_timeout,
  output logic [1:0]  ctrl_state
`ifdef HAZARD_STALL_COUNTER_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {S_RUN = 2'd0, S_STALL = 2'd1, S_FLUSH = 2'd2, S_HOLD = 2'd3} state_t;

  state_t     r_state, r_saved;
  logic [1:0] r_flush_cnt;
  logic [7:0] r_hold_cnt;
  logic       r_timeout;

  state_t     w_next_state, w_next_saved, w_eff;
  logic [1:0] w_next_flush_cnt;
  logic [7:0] w_hold_next;
  logic       w_hazard, w_uses_rt;
  logic [5:0] w_op;
  logic [4:0] w_rs, w_rt;
  logic       w_unused;

  assign w_op     = ins_id[31:26];
  assign w_rs     = ins_id[25:21];
  assign w_rt     = ins_id[20:16];
  assign w_unused = ^{ins_id[15:0], LOAD_OP};

  assign w_uses_rt = (w_op == RTYPE_OP) || (w_op == STORE_OP);
  assign w_hazard  = id_valid && ex_is_load && (ex_rd != 5'd0) &&
                     ((ex_rd == w_rs) || (w_uses_rt && (ex_rd == w_rt)));

  // A HOLD that ends this cycle behaves exactly like the state it interrupted.
  assign w_eff = (r_state == S_HOLD) ? r_saved : r_state;

  assign w_hold_next = (r_hold_cnt == 8'hFF) ? 8'hFF : r_hold_cnt + 8'd1;

  // State register and counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_RUN;
      r_saved     <= S_RUN;
      r_flush_cnt <= 2'd0;
      r_hold_cnt  <= 8'd0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_saved     <= w_next_saved;
      r_flush_cnt <= w_next_flush_cnt;
      r_hold_cnt  <= mem_wait ? w_hold_next : 8'd0;
      if (mem_wait && (w_hold_next == 8'(MAX_HOLD)))
        r_timeout <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state     = r_state;
    w_next_saved     = r_saved;
    w_next_flush_cnt = r_flush_cnt;
    if (mem_wait) begin
      w_next_state = S_HOLD;
      if (r_state != S_HOLD)
        w_next_saved = r_state;
    end else begin
      case (w_eff)
        S_RUN: begin
          if (branch_taken) begin
            if (FLUSH_CYCLES > 1) begin
              w_next_state     = S_FLUSH;
              w_next_flush_cnt = 2'(FLUSH_CYCLES - 1);
            end else begin
              w_next_state = S_RUN;
            end
          end else if (w_hazard) begin
            w_next_state = S_STALL;
          end else begin
            w_next_state = S_RUN;
          end
        end
        S_STALL: w_next_state = S_RUN;
        S_FLUSH: begin
          // The branch cycle itself was the first flush, so leave on the last count.
          if (r_flush_cnt <= 2'd1) begin
            w_next_state     = S_RUN;
            w_next_flush_cnt = 2'd0;
          end else begin
            w_next_state     = S_FLUSH;
            w_next_flush_cnt = r_flush_cnt - 2'd1;
          end
        end
        default: w_next_state = S_RUN;
      endcase
    end
  end

  // Mealy output decode
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    if (reset && !mem_wait) begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      case (w_eff)
        S_RUN: begin
          if (branch_taken) begin
            idex_bubble = 1'b1;
            ifid_flush  = 1'b1;
          end else if (w_hazard) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
          end
        end
        S_FLUSH: begin
          idex_bubble = 1'b1;
          ifid_flush  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign hold_timeout = r_timeout;
  assign ctrl_state   = r_state;

`ifdef HAZARD_STALL_COUNTER_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_stall_cnt <= 16'd0;
    else if (!pc_en)
      r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 Parameter LOAD_OP, default 6'b010100, opcode of a load word instruction.
REQ-002 Parameter STORE_OP, default 6'b010101, opcode of a store instruction; rt is a source register.
REQ-003 Parameter RTYPE_OP, default 6'b000000, opcode of an R-type instruction; rt is a source register.
REQ-004 Parameter FLUSH_CYCLES, default 2, legal range 1..3, number of cycles the front end is flushed after a taken branch.
REQ-005 Parameter MAX_HOLD, default 8, legal range 1..255, consecutive mem_wait cycles after which a timeout is flagged.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 ins_id  input  32  decode-stage instruction: op [31:26], rs [25:21], rt [20:16].
REQ-009 id_valid  input  1  ins_id holds a real instruction, not a bubble.
REQ-010 ex_is_load  input  1  the EX-stage instruction is a load.
REQ-011 ex_rd  input  5  destination register of the EX-stage instruction.
REQ-012 branch_taken  input  1  a branch resolved taken in EX this cycle.
REQ-013 mem_wait  input  1  data memory is not ready; the whole pipeline must freeze.
REQ-014 pc_en, ifid_en, idex_en, exmem_en  output  1 each  pipeline register enables.
REQ-015 idex_bubble  output  1  load a NOP into ID/EX.
REQ-016 ifid_flush  output  1  clear IF/ID.
REQ-017 hold_timeout  output  1  sticky flag: mem_wait exceeded MAX_HOLD.
REQ-018 ctrl_state  output  2  current state: RUN=0, STALL=1, FLUSH=2, HOLD=3.

Function
REQ-019 The hazard term SHALL be: id_valid & ex_is_load & (ex_rd!=0) & (ex_rd==rs | (uses_rt & ex_rd==rt)); uses_rt = op is RTYPE_OP or STORE_OP.
REQ-020 Outputs SHALL be Mealy-decoded from the registered state and the current inputs, with priority mem_wait > FLUSH state / branch_taken > hazard.
REQ-021 With mem_wait=1, in any state, the block SHALL drive all four enables 0, idex_bubble 0 and ifid_flush 0, and SHALL enter or remain in HOLD.
REQ-022 In HOLD with mem_wait=0, the block SHALL return to the state saved on entry to HOLD; a saved FLUSH state resumes with its remaining count.
REQ-023 In RUN with branch_taken=1, the block SHALL drive pc_en=1, ifid_flush=1 and idex_bubble=1, and SHALL go to FLUSH with the counter loaded to FLUSH_CYCLES-1 (RUN directly if FLUSH_CYCLES=1).
REQ-024 In FLUSH, each cycle the block SHALL drive ifid_flush=1, idex_bubble=1 and pc_en=1, decrement the counter, and exit to RUN when the counter is 0; branch_taken and hazard are ignored in FLUSH.
REQ-025 In RUN with a hazard and no branch, the block SHALL drive pc_en=0, ifid_en=0, idex_bubble=1, idex_en=1 and exmem_en=1, and SHALL go to STALL.
REQ-026 STALL SHALL last exactly one cycle with all enables 1; the block SHALL return to RUN, and may re-enter STALL only on a new hazard evaluated in RUN.
REQ-027 In RUN with no event, the block SHALL drive all enables 1, idex_bubble 0 and ifid_flush 0.
REQ-028 The 8-bit hold counter SHALL count consecutive mem_wait cycles, saturate at 255, and clear when mem_wait=0; hold_timeout SHALL set when the count reaches MAX_HOLD and stay set until reset.

Reset
REQ-029 While reset=0, the block SHALL force state RUN, counters 0, hold_timeout 0 and all outputs 0, asynchronously and including mid-FLUSH or mid-HOLD.
REQ-030 On the first clock after reset rises, the block SHALL be in RUN and drive normal RUN outputs.

Configuration
REQ-031 With macro HAZARD_STALL_COUNTER_EN defined, a 16-bit output stall_cnt SHALL count cycles with pc_en=0 while reset=1, wrap from 16'hFFFF to 0, and reset to 0.
REQ-032 Without HAZARD_STALL_COUNTER_EN, stall_cnt and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-033 Load-use: ex_is_load=1, ex_rd=1, ins_id=32'h00221800, id_valid=1 -> one cycle of pc_en=0, ifid_en=0, idex_bubble=1, then state RUN with all enables 1.
REQ-034 No false hazard: ex_rd=1 with ins_id=32'h34C10005 (rt=1, rt not a source) -> no stall; the same case with ex_rd=0 -> no stall.
REQ-035 Branch: branch_taken=1 in RUN, FLUSH_CYCLES=2 -> ifid_flush=1 for 2 consecutive cycles, then RUN; a hazard during FLUSH is ignored.
REQ-036 Hold: mem_wait=1 for 9 cycles with MAX_HOLD=8 -> enables 0 throughout, hold_timeout rises on the 8th cycle and stays 1; mem_wait arriving mid-FLUSH resumes FLUSH with the remaining count.
REQ-037 Reset: reset=0 asserted mid-FLUSH -> outputs 0 immediately; after release, RUN with stall_cnt=0 when HAZARD_STALL_COUNTER_EN is defined.
